rr_arbiter_burst: RTL

- Parametrised N-way round-robin arbiter with registered one-hot grant and bounded burst ownership.
- A winner keeps the grant while it keeps requesting, up to MAX_BURST consecutive cycles; then fairness forces rotation.
- Sits in front of shared resources (memory port, bus) where multiple masters contend.
- Generalises the 2-request arbiter to N requesters with burst hold and an encoded grant index.

---
 rtl/rr_arb_pkg.sv | 28 ++
 rtl/rr_arb_pick.sv | 41 ++++
 rtl/rr_arbiter_burst.sv | 130 +++++++++++++
 3 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin burst arbiter.
// The one-hot helpers work on a fixed 32-bit vector, so N is limited to 32 requesters.
package rr_arb_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_t;

    // Widest requester vector the helpers below accept.
    localparam int unsigned MaxN = 32;

    // Encode a one-hot vector to its bit index; a zero vector yields 0.
    function automatic logic [4:0] onehot_to_idx(input logic [MaxN-1:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < MaxN; i++) begin
            if (oh[i]) idx = idx | 5'(i);
        end
        return idx;
    endfunction

    // True when at most one bit of v is set.
    function automatic logic is_onehot0(input logic [MaxN-1:0] v);
        return (v & (v - MaxN'(1))) == '0;
    endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Cyclic priority search: first set bit of req_eff_i starting at ptr_i and wrapping at N.
// The request vector is duplicated and shifted down by ptr_i so a plain
// lowest-bit-first search over N bits sees the requesters in cyclic order.
module rr_arb_pick #(
    parameter int unsigned N = 4,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_eff_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] win_idx_o
);

    localparam logic [IDX_W:0] NumReq = (IDX_W + 1)'(N);

    logic [2*N-1:0]   req_dbl;
    logic [2*N-1:0]   req_shift;
    logic [N-1:0]     req_rot;
    logic [IDX_W-1:0] offset;
    logic [IDX_W:0]   sum;

    assign req_dbl   = {req_eff_i, req_eff_i};
    assign req_shift = req_dbl >> ptr_i;
    assign req_rot   = req_shift[N-1:0];

    // Lowest set bit of the rotated vector is the distance from ptr_i to the winner.
    always_comb begin
        offset = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_rot[k]) offset = IDX_W'(k);
        end
    end

    // Undo the rotation modulo N.
    always_comb begin
        sum       = {1'b0, ptr_i} + {1'b0, offset};
        found_o   = |req_rot;
        win_idx_o = (sum >= NumReq) ? IDX_W'(sum - NumReq) : sum[IDX_W-1:0];
    end

endmodule

// File: rtl/rr_arbiter_burst.sv
// N-way round-robin arbiter with registered one-hot grant and bounded burst ownership.
// An owner keeps the grant while requesting, for at most MAX_BURST consecutive cycles;
// on release the next winner is picked in the same cycle (no idle bubble).
// Optional: define RR_ARBITER_BURST_MASK_EN to add req_mask_i (effective req = req & mask).
// Legal ranges: 2 <= N <= 32, MAX_BURST >= 1.
module rr_arbiter_burst
    import rr_arb_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned MAX_BURST = 4,
    localparam int unsigned IDX_W = $clog2(N),
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_i,
`ifdef RR_ARBITER_BURST_MASK_EN
    input  logic [N-1:0]     req_mask_i,
`endif
    output logic [N-1:0]     grant_o,
    output logic             grant_valid_o,
    output logic [IDX_W-1:0] grant_idx_o
);

    localparam logic [N-1:0]     OneHot0  = N'(1);
    localparam logic [IDX_W-1:0] LastIdx  = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0] BurstMax = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [N-1:0]     grant_q, grant_d;
    logic             grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;

    logic [N-1:0]     req_eff;
    logic             found;
    logic [IDX_W-1:0] win_idx;
    logic             owner_done;

`ifdef RR_ARBITER_BURST_MASK_EN
    assign req_eff = req_i & req_mask_i;
`else
    assign req_eff = req_i;
`endif

    // The owner is released when it stops requesting or has used up its burst.
    assign owner_done = !req_eff[grant_idx_q] || (burst_cnt_q == BurstMax);

    rr_arb_pick #(
        .N (N)
    ) u_pick (
        .req_eff_i (req_eff),
        .ptr_i     (ptr_q),
        .found_o   (found),
        .win_idx_o (win_idx)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: leave idle on any request, go idle when a release finds no one.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (found) state_d = StBusy;
            StBusy: if (owner_done && !found) state_d = StIdle;
        endcase
    end

    // Output / datapath next values: hold, hand over to a new winner, or clear.
    always_comb begin
        ptr_d         = ptr_q;
        burst_cnt_d   = burst_cnt_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        grant_idx_d   = grant_idx_q;
        if (state_q == StBusy && !owner_done) begin
            burst_cnt_d = burst_cnt_q + CntOne;
        end else if (found) begin
            grant_d       = OneHot0 << win_idx;
            grant_valid_d = 1'b1;
            grant_idx_d   = win_idx;
            burst_cnt_d   = CntOne;
            ptr_d         = (win_idx == LastIdx) ? '0 : win_idx + 1'b1;
        end else begin
            grant_d       = '0;
            grant_valid_d = 1'b0;
            grant_idx_d   = '0;
            burst_cnt_d   = '0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q         <= '0;
            burst_cnt_q   <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
        end else begin
            ptr_q         <= ptr_d;
            burst_cnt_q   <= burst_cnt_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_idx_q   <= grant_idx_d;
        end
    end

    // Grant must be one-hot or zero and agree with the encoded index.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (is_onehot0(MaxN'(grant_q)));
            assert (!grant_valid_q || grant_idx_q == IDX_W'(onehot_to_idx(MaxN'(grant_q))));
        end
    end

    assign grant_o       = grant_q;
    assign grant_valid_o = grant_valid_q;
    assign grant_idx_o   = grant_idx_q;

endmodule
